// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// =============================================================================
// Module  : stopwatch_ctrl
// Brief   : Start/pause/clear sequencer and 1 s tick for an MM:SS stopwatch or
//           countdown timer built from two cascaded count00to59 counters.
// Rev     : 1.0  initial release
// =============================================================================
module stopwatch_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int PW       = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       mode_down,
  input  logic [3:0] sec_msd,
  input  logic [3:0] sec_lsd,
  input  logic [3:0] min_msd,
  input  logic [3:0] min_lsd,
  output logic       sec_en,
  output logic       min_en,
  output logic       cnt_up,
  output logic       cnt_reset,
  output logic       running,
  output logic       alarm
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [PW-1:0] C_LAST = PW'(TICK_DIV - 1);

  state_t        r_state;
  state_t        w_next;
  logic [PW-1:0] r_presc;
  logic          r_tick;
  logic          r_dir_down;
  logic          r_cnt_reset;
  logic          r_running;
  logic          r_alarm;

  logic w_all_zero;
  logic w_sec_term;
  logic w_in_run;
  logic w_cd_expire;
  logic w_stay_run;
  logic w_wrap;

  assign w_all_zero = (sec_msd == 4'd0) && (sec_lsd == 4'd0) &&
                      (min_msd == 4'd0) && (min_lsd == 4'd0);
  // Out-of-range digits never match either terminal pattern.
  assign w_sec_term = r_dir_down ? ((sec_msd == 4'd0) && (sec_lsd == 4'd0))
                                 : ((sec_msd == 4'd5) && (sec_lsd == 4'd9));
  assign w_in_run    = (r_state == S_RUN);
  assign w_cd_expire = r_tick & w_in_run & r_dir_down & w_all_zero;

  always_comb begin
    w_next = r_state;
    if (clear) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start_stop) w_next = (mode_down && w_all_zero) ? S_DONE : S_RUN;
        S_RUN: begin
          if (start_stop)       w_next = S_PAUSE;
          else if (w_cd_expire) w_next = S_DONE;
        end
        S_PAUSE: if (start_stop) w_next = S_RUN;
        S_DONE:  if (start_stop) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Prescaler only advances while RUN persists, so every entry into RUN
  // restarts a full tick period.
  assign w_stay_run = w_in_run && (w_next == S_RUN);
  assign w_wrap     = (r_presc == C_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_tick      <= 1'b0;
      r_dir_down  <= 1'b0;
      r_cnt_reset <= 1'b1;
      r_running   <= 1'b0;
      r_alarm     <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt_reset <= clear;
      r_running   <= (w_next == S_RUN);
      r_alarm     <= (w_next == S_DONE);
      if ((r_state == S_IDLE) && (w_next != S_IDLE))
        r_dir_down <= mode_down;
      if (w_stay_run) begin
        r_presc <= w_wrap ? '0 : r_presc + PW'(1);
        r_tick  <= w_wrap;
      end else begin
        r_presc <= '0;
        r_tick  <= 1'b0;
      end
    end
  end

  assign sec_en    = r_tick & w_in_run & ~(r_dir_down & w_all_zero);
  assign min_en    = sec_en & w_sec_term;
  assign cnt_up    = ~r_dir_down;
  assign cnt_reset = r_cnt_reset;
  assign running   = r_running;
  assign alarm     = r_alarm;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// =============================================================================
// Module  : tb_stopwatch_ctrl
// Brief   : Self-checking bench: counter-pair plant plus a time-in-seconds
//           reference model of the stopwatch controller.
// Rev     : 1.0  initial release
// =============================================================================
module tb_stopwatch_ctrl;

  localparam int TICK_DIV = 4;
  localparam int PW       = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic       clk        = 1'b0;
  logic       reset      = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear      = 1'b0;
  logic       mode_down  = 1'b0;
  logic [3:0] sec_msd, sec_lsd, min_msd, min_lsd;
  logic       sec_en, min_en, cnt_up, cnt_reset, running, alarm;

  int n_checks = 0;
  int n_pass   = 0;

  // counter-pair plant driven by the DUT enables
  int   p_sec   = 0;
  int   p_min   = 0;
  logic pre_req = 1'b0;
  int   pre_val = 0;

  // reference model: mode, cycles spent in the current run, and total seconds
  int   m_state = M_IDLE;
  int   m_el    = 0;
  logic m_down  = 1'b0;
  logic m_crst  = 1'b1;
  int   m_time  = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .PW(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_stop (start_stop),
    .clear      (clear),
    .mode_down  (mode_down),
    .sec_msd    (sec_msd),
    .sec_lsd    (sec_lsd),
    .min_msd    (min_msd),
    .min_lsd    (min_lsd),
    .sec_en     (sec_en),
    .min_en     (min_en),
    .cnt_up     (cnt_up),
    .cnt_reset  (cnt_reset),
    .running    (running),
    .alarm      (alarm)
  );

  assign sec_msd = 4'(p_sec / 10);
  assign sec_lsd = 4'(p_sec % 10);
  assign min_msd = 4'(p_min / 10);
  assign min_lsd = 4'(p_min % 10);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic bit e_tick();
    return (m_state == M_RUN) && (m_el > 0) && ((m_el % TICK_DIV) == 0);
  endfunction

  function automatic bit e_sec_en();
    return e_tick() && !(m_down && (m_time == 0));
  endfunction

  function automatic bit e_min_en();
    return e_sec_en() && (m_down ? ((m_time % 60) == 0) : ((m_time % 60) == 59));
  endfunction

  function automatic int f_next(input bit ss, input bit clr, input bit md);
    if (clr) return M_IDLE;
    case (m_state)
      M_IDLE:  if (ss) return (md && (m_time == 0)) ? M_DONE : M_RUN;
      M_RUN: begin
        if (ss) return M_PAUSE;
        if (e_tick() && m_down && (m_time == 0)) return M_DONE;
      end
      M_PAUSE: if (ss) return M_RUN;
      M_DONE:  if (ss) return M_IDLE;
      default: ;
    endcase
    return m_state;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state <= M_IDLE;
      m_el    <= 0;
      m_down  <= 1'b0;
      m_crst  <= 1'b1;
    end else begin
      m_state <= f_next(start_stop, clear, mode_down);
      m_el    <= ((m_state == M_RUN) && (f_next(start_stop, clear, mode_down) == M_RUN)) ? m_el + 1 : 0;
      m_crst  <= clear;
      if ((m_state == M_IDLE) && (f_next(start_stop, clear, mode_down) != M_IDLE))
        m_down <= mode_down;
    end
  end

  always @(posedge clk) begin
    if (pre_req)         m_time <= pre_val;
    else if (m_crst)     m_time <= 0;
    else if (e_sec_en()) m_time <= m_down ? m_time - 1 : (m_time + 1) % 3600;
  end

  always @(posedge clk) begin
    if (pre_req) begin
      p_sec <= pre_val % 60;
      p_min <= pre_val / 60;
    end else if (cnt_reset) begin
      p_sec <= 0;
      p_min <= 0;
    end else begin
      if (sec_en) p_sec <= cnt_up ? ((p_sec == 59) ? 0 : p_sec + 1) : ((p_sec == 0) ? 59 : p_sec - 1);
      if (min_en) p_min <= cnt_up ? ((p_min == 59) ? 0 : p_min + 1) : ((p_min == 0) ? 59 : p_min - 1);
    end
  end

  always @(negedge clk) begin
    check("running",   running,   m_state == M_RUN);
    check("alarm",     alarm,     m_state == M_DONE);
    check("sec_en",    sec_en,    e_sec_en());
    check("min_en",    min_en,    e_min_en());
    check("cnt_up",    cnt_up,    !m_down);
    check("cnt_reset", cnt_reset, m_crst);
    check("time",      p_min * 60 + p_sec, m_time);
  end

  task automatic step(input bit ss, input bit clr, input bit md, input int pre = -1);
    @(negedge clk);
    start_stop = ss;
    clear      = clr;
    mode_down  = md;
    pre_req    = (pre >= 0);
    pre_val    = (pre >= 0) ? pre : 0;
  endtask

  task automatic idle(input int n, input bit md = 1'b0);
    repeat (n) step(1'b0, 1'b0, md);
  endtask

  // cycles from the first cycle in RUN to the first sec_en, bounded
  task automatic tick_latency(input string tag, input bit md);
    int k;
    k = 0;
    while (k < 20) begin
      step(1'b0, 1'b0, md);
      if (sec_en) break;
      k++;
    end
    check(tag, k, TICK_DIV);
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_running", running, 0);
    check("rst_alarm",   alarm,   0);
    check("rst_sec_en",  sec_en,  0);
    reset = 1'b0;
    #1 check("rel_cnt_reset", cnt_reset, 1);
    idle(1);
    check("rel_cnt_reset_gone", cnt_reset, 0);
    idle(1);

    // up count from 00:00 through 00:59 -> 01:00
    step(1'b1, 1'b0, 1'b0);
    tick_latency("first_tick", 1'b0);
    check("up_cnt_up", cnt_up, 1);
    idle(250);

    // pause with mode_down wiggled, then resume
    step(1'b1, 1'b0, 1'b0);
    idle(8, 1'b1);
    check("pause_cnt_up", cnt_up, 1);
    step(1'b1, 1'b0, 1'b1);
    tick_latency("resume_tick", 1'b1);
    check("resume_cnt_up", cnt_up, 1);

    // 59:50 up through the full wrap
    step(1'b0, 1'b1, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 1'b0, 3590);
    step(1'b1, 1'b0, 1'b0);
    idle(60);

    // countdown from 01:00 to alarm
    step(1'b0, 1'b1, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 1'b0, 60);
    step(1'b1, 1'b0, 1'b1);
    tick_latency("cd_first_tick", 1'b1);
    check("cd_min_en", min_en, 1);
    check("cd_cnt_up", cnt_up, 0);
    idle(260, 1'b1);
    check("cd_alarm", alarm, 1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("cd_alarm_clr", alarm, 0);

    // countdown requested at 00:00 goes straight to DONE
    step(1'b0, 1'b1, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("zero_alarm", alarm, 1);
    idle(10, 1'b1);
    step(1'b1, 1'b0, 1'b0);

    // clear wins over start_stop while running
    idle(2);
    step(1'b1, 1'b0, 1'b0);
    idle(6);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("clr_ss_running",   running,   0);
    check("clr_ss_cnt_reset", cnt_reset, 1);
    idle(3);
    step(1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);

    // randomized button traffic with occasional presets while idle
    for (int i = 0; i < 1500; i++) begin
      bit ss, clr, md;
      int pre;
      ss  = ($urandom_range(0, 7) == 0);
      clr = ($urandom_range(0, 39) == 0);
      md  = 1'($urandom_range(0, 1));
      pre = -1;
      if ((m_state == M_IDLE) && !ss && ($urandom_range(0, 9) == 0))
        pre = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 3599));
      step(ss, clr, md, pre);
    end

    // asynchronous reset in the middle of a run
    step(1'b0, 1'b1, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 1'b0);
    idle(6);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check("async_rst_running", running, 0);
    @(negedge clk);
    reset = 1'b0;
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
